// File: rtl/ysyx_23060124_clint_pkg.sv
// ============================================================================
// Module      : ysyx_23060124_clint_pkg
// Description : Shared widths, register offsets, response codes and helpers
//               for the AXI4-Lite core-local interruptor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ysyx_23060124_ISA_WIDTH
`define ysyx_23060124_ISA_WIDTH 32
`endif
`ifndef ysyx_23060124_ISA_ADDR_WIDTH
`define ysyx_23060124_ISA_ADDR_WIDTH 32
`endif
`ifndef ysyx_23060124_OPT_WIDTH
`define ysyx_23060124_OPT_WIDTH 4
`endif

package ysyx_23060124_clint_pkg;

    localparam logic [31:0] c_off_msip        = 32'h0000_0000;
    localparam logic [31:0] c_off_mtimecmp_lo = 32'h0000_4000;
    localparam logic [31:0] c_off_mtimecmp_hi = 32'h0000_4004;
    localparam logic [31:0] c_off_mtime_lo    = 32'h0000_BFF8;
    localparam logic [31:0] c_off_mtime_hi    = 32'h0000_BFFC;

    localparam logic [1:0]  c_resp_okay   = 2'b00;
    localparam logic [1:0]  c_resp_slverr = 2'b10;

    localparam logic [63:0] c_mtimecmp_rst = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_CMP_LO,
        SEL_CMP_HI,
        SEL_TIME_LO,
        SEL_TIME_HI
    } reg_sel_e;

    typedef enum logic [0:0] {
        W_IDLE,
        W_RESP
    } wstate_e;

    typedef enum logic [0:0] {
        R_IDLE,
        R_DATA
    } rstate_e;

    // Byte-lane offset bits are don't-care, so they are masked before matching.
    function automatic reg_sel_e decode_offset(input logic [31:0] offset);
        reg_sel_e sel;
        case (offset & 32'hFFFF_FFFC)
            c_off_msip:        sel = SEL_MSIP;
            c_off_mtimecmp_lo: sel = SEL_CMP_LO;
            c_off_mtimecmp_hi: sel = SEL_CMP_HI;
            c_off_mtime_lo:    sel = SEL_TIME_LO;
            c_off_mtime_hi:    sel = SEL_TIME_HI;
            default:           sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_23060124_clint_regs.sv
// ============================================================================
// Module      : ysyx_23060124_clint_regs
// Description : mtime counter with prescaler, mtimecmp, msip and timer compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060124_clint_regs
    import ysyx_23060124_clint_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_en,
    input  reg_sel_e    i_wr_sel,
    input  logic [31:0] i_wr_data,
    input  logic [3:0]  i_wr_strb,
    output logic [63:0] o_mtime,
    output logic [63:0] o_mtimecmp,
    output logic        o_msip,
    output logic        o_mtip
);

    localparam int                 c_cnt_w   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(PRESCALE - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic [63:0]        r_mtime;
    logic [63:0]        r_mtimecmp;
    logic               r_msip;
    logic               r_mtip;
    logic               w_tick;

    assign w_tick = (r_cnt == c_cnt_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A CPU write to either half suppresses that cycle's increment entirely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtime <= '0;
        end else if (i_wr_en && i_wr_sel == SEL_TIME_LO) begin
            r_mtime[31:0] <= strb_merge(r_mtime[31:0], i_wr_data, i_wr_strb);
        end else if (i_wr_en && i_wr_sel == SEL_TIME_HI) begin
            r_mtime[63:32] <= strb_merge(r_mtime[63:32], i_wr_data, i_wr_strb);
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtimecmp <= c_mtimecmp_rst;
            r_msip     <= 1'b0;
            r_mtip     <= 1'b0;
        end else begin
            if (i_wr_en && i_wr_sel == SEL_CMP_LO) begin
                r_mtimecmp[31:0] <= strb_merge(r_mtimecmp[31:0], i_wr_data, i_wr_strb);
            end
            if (i_wr_en && i_wr_sel == SEL_CMP_HI) begin
                r_mtimecmp[63:32] <= strb_merge(r_mtimecmp[63:32], i_wr_data, i_wr_strb);
            end
            if (i_wr_en && i_wr_sel == SEL_MSIP && i_wr_strb[0]) begin
                r_msip <= i_wr_data[0];
            end
            r_mtip <= (r_mtime >= r_mtimecmp);
        end
    end

    assign o_mtime    = r_mtime;
    assign o_mtimecmp = r_mtimecmp;
    assign o_msip     = r_msip;
    assign o_mtip     = r_mtip;

endmodule

`default_nettype wire

// File: rtl/ysyx_23060124_axi_clint.sv
// ============================================================================
// Module      : ysyx_23060124_axi_clint
// Description : AXI4-Lite responder front end (independent read/write FSMs
//               and address decode) for the core-local interruptor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060124_axi_clint
    import ysyx_23060124_clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic                                     S_AXI_ACLK,
    input  logic                                     S_AXI_ARESET,
    input  logic [`ysyx_23060124_ISA_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                                     S_AXI_AWVALID,
    output logic                                     S_AXI_AWREADY,
    input  logic [`ysyx_23060124_ISA_WIDTH-1:0]      S_AXI_WDATA,
    input  logic [`ysyx_23060124_OPT_WIDTH-1:0]      S_AXI_WSTRB,
    input  logic                                     S_AXI_WVALID,
    output logic                                     S_AXI_WREADY,
    output logic [1:0]                               S_AXI_BRESP,
    output logic                                     S_AXI_BVALID,
    input  logic                                     S_AXI_BREADY,
    input  logic [`ysyx_23060124_ISA_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                                     S_AXI_ARVALID,
    output logic                                     S_AXI_ARREADY,
    output logic [`ysyx_23060124_ISA_WIDTH-1:0]      S_AXI_RDATA,
    output logic [1:0]                               S_AXI_RRESP,
    output logic                                     S_AXI_RVALID,
    input  logic                                     S_AXI_RREADY,
    output logic                                     o_mtip,
    output logic                                     o_msip
);

    logic [63:0] w_mtime;
    logic [63:0] w_mtimecmp;
    logic        w_msip;

    wstate_e     r_wstate, w_wstate_nxt;
    rstate_e     r_rstate, w_rstate_nxt;

    logic        r_aw_held, r_w_held;
    logic [31:0] r_awaddr, r_wdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_bresp;
    logic        w_aw_hs, w_w_hs, w_commit;
    logic [31:0] w_wr_addr, w_wr_data;
    logic [3:0]  w_wr_strb;
    reg_sel_e    w_wr_sel;

    logic        w_ar_hs;
    reg_sel_e    w_rd_sel;
    logic [31:0] w_rd_val;
    logic [31:0] r_rdata, r_shadow_hi;
    logic [1:0]  r_rresp;
    logic        r_last_lo;

    // ---------------- write channel ----------------
    assign S_AXI_AWREADY = (r_wstate == W_IDLE) && !r_aw_held;
    assign S_AXI_WREADY  = (r_wstate == W_IDLE) && !r_w_held;
    assign w_aw_hs       = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs        = S_AXI_WVALID && S_AXI_WREADY;
    assign w_wr_addr     = r_aw_held ? r_awaddr : S_AXI_AWADDR;
    assign w_wr_data     = r_w_held ? r_wdata : S_AXI_WDATA;
    assign w_wr_strb     = r_w_held ? r_wstrb : S_AXI_WSTRB;
    assign w_wr_sel      = decode_offset(w_wr_addr - BASE_ADDR);
    assign w_commit      = (r_wstate == W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign S_AXI_BVALID  = (r_wstate == W_RESP);
    assign S_AXI_BRESP   = r_bresp;

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) r_wstate <= W_IDLE;
        else              r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_commit) w_wstate_nxt = W_RESP;
            W_RESP:  if (S_AXI_BREADY) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= c_resp_okay;
        end else if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bresp   <= (w_wr_sel == SEL_NONE) ? c_resp_slverr : c_resp_okay;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= S_AXI_AWADDR;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= S_AXI_WDATA;
                r_wstrb  <= S_AXI_WSTRB;
            end
        end
    end

    // ---------------- read channel ----------------
    assign S_AXI_ARREADY = (r_rstate == R_IDLE);
    assign w_ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;
    assign w_rd_sel      = decode_offset(S_AXI_ARADDR - BASE_ADDR);
    assign S_AXI_RVALID  = (r_rstate == R_DATA);
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) r_rstate <= R_IDLE;
        else              r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA:  if (S_AXI_RREADY) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // The hi half comes from the shadow only directly after a lo read, giving a tear-free pair.
    always_comb begin
        w_rd_val = '0;
        case (w_rd_sel)
            SEL_MSIP:    w_rd_val = {31'b0, w_msip};
            SEL_CMP_LO:  w_rd_val = w_mtimecmp[31:0];
            SEL_CMP_HI:  w_rd_val = w_mtimecmp[63:32];
            SEL_TIME_LO: w_rd_val = w_mtime[31:0];
            SEL_TIME_HI: w_rd_val = r_last_lo ? r_shadow_hi : w_mtime[63:32];
            default:     w_rd_val = '0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_rdata     <= '0;
            r_rresp     <= c_resp_okay;
            r_shadow_hi <= '0;
            r_last_lo   <= 1'b0;
        end else if (w_ar_hs) begin
            r_rdata   <= w_rd_val;
            r_rresp   <= (w_rd_sel == SEL_NONE) ? c_resp_slverr : c_resp_okay;
            r_last_lo <= (w_rd_sel == SEL_TIME_LO);
            if (w_rd_sel == SEL_TIME_LO) r_shadow_hi <= w_mtime[63:32];
        end
    end

    ysyx_23060124_clint_regs #(
        .PRESCALE (PRESCALE)
    ) u_regs (
        .clk        (S_AXI_ACLK),
        .rst        (S_AXI_ARESET),
        .i_wr_en    (w_commit && (w_wr_sel != SEL_NONE)),
        .i_wr_sel   (w_wr_sel),
        .i_wr_data  (w_wr_data),
        .i_wr_strb  (w_wr_strb),
        .o_mtime    (w_mtime),
        .o_mtimecmp (w_mtimecmp),
        .o_msip     (w_msip),
        .o_mtip     (o_mtip)
    );

    assign o_msip = w_msip;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060124_axi_clint.sv
// ============================================================================
// Module      : tb_ysyx_23060124_axi_clint
// Description : Self-checking bench for the AXI4-Lite core-local interruptor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060124_axi_clint;

    localparam logic [31:0] c_base   = 32'h0200_0000;
    localparam logic [31:0] c_msip   = c_base + 32'h0000;
    localparam logic [31:0] c_cmp_lo = c_base + 32'h4000;
    localparam logic [31:0] c_cmp_hi = c_base + 32'h4004;
    localparam logic [31:0] c_t_lo   = c_base + 32'hBFF8;
    localparam logic [31:0] c_t_hi   = c_base + 32'hBFFC;
    localparam logic [31:0] c_bad    = c_base + 32'h1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid, mtip, msip;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_23060124_axi_clint dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .o_mtip        (mtip),
        .o_msip        (msip)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input logic [63:0] act,
                           input logic [63:0] lo, input logic [63:0] hi);
        total++;
        if ($isunknown(act) || act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %h expected in [%h,%h]", name, act, lo, hi);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
        int cyc = 0;
        bit aw_ok = 0, w_ok = 0, aw_hs, w_hs, stable = 1;
        awaddr = addr;
        wdata  = data;
        wstrb  = strb;
        while (!(aw_ok && w_ok) && cyc < 64) begin
            awvalid = !aw_ok && (cyc >= aw_dly);
            wvalid  = !w_ok && (cyc >= w_dly);
            aw_hs   = awvalid && awready;
            w_hs    = wvalid && wready;
            @(posedge clk); #1;
            cyc++;
            if (aw_hs) aw_ok = 1;
            if (w_hs)  w_ok  = 1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("bvalid_rise", bvalid, 1);
        resp = bresp;
        for (int i = 0; i < b_dly; i++) begin
            @(posedge clk); #1;
            if (!bvalid || bresp !== resp || awready || wready) stable = 0;
        end
        if (b_dly > 0) chk("bvalid_hold", stable, 1);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        chk("bvalid_drop", bvalid, 0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp);
        int cyc = 0;
        bit ok = 0, hs, stable = 1;
        araddr = addr;
        while (!ok && cyc < 64) begin
            arvalid = 1'b1;
            hs = arready;
            @(posedge clk); #1;
            cyc++;
            ok = hs;
        end
        arvalid = 1'b0;
        chk("rvalid_rise", rvalid, 1);
        data = rdata;
        resp = rresp;
        for (int i = 0; i < r_dly; i++) begin
            @(posedge clk); #1;
            if (!rvalid || rdata !== data || rresp !== resp || arready) stable = 0;
        end
        if (r_dly > 0) chk("rvalid_hold", stable, 1);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return r;
    endfunction

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
        bit          msip;
    } vec_t;

    vec_t        vecs[14];
    logic [31:0] d, a, v, v2, m_lo, m_hi, exp_d;
    logic [1:0]  r;
    logic [3:0]  s;
    bit          m_msip;
    int          pick, n_wait;
    logic [31:0] bad_addrs[4];

    initial begin
        vecs[0]  = '{1, c_msip,            32'h1,         4'b0000, 2'b00, 32'h0,         0};
        vecs[1]  = '{0, c_msip,            32'h0,         4'b0000, 2'b00, 32'h0,         0};
        vecs[2]  = '{1, c_msip,            32'h1,         4'b0001, 2'b00, 32'h0,         1};
        vecs[3]  = '{0, c_msip + 32'h3,    32'h0,         4'b0000, 2'b00, 32'h1,         1};
        vecs[4]  = '{1, c_msip,            32'hFFFF_FFFE, 4'b1111, 2'b00, 32'h0,         0};
        vecs[5]  = '{0, c_msip,            32'h0,         4'b0000, 2'b00, 32'h0,         0};
        vecs[6]  = '{1, c_cmp_hi,          32'hFFFF_FFFF, 4'b1111, 2'b00, 32'h0,         0};
        vecs[7]  = '{1, c_cmp_lo,          32'hDEAD_BEEF, 4'b1111, 2'b00, 32'h0,         0};
        vecs[8]  = '{1, c_cmp_lo,          32'h1122_3344, 4'b0101, 2'b00, 32'h0,         0};
        vecs[9]  = '{0, c_cmp_lo,          32'h0,         4'b0000, 2'b00, 32'hDE22_BE44, 0};
        vecs[10] = '{1, c_bad,             32'h1234_5678, 4'b1111, 2'b10, 32'h0,         0};
        vecs[11] = '{0, c_bad,             32'h0,         4'b0000, 2'b10, 32'h0,         0};
        vecs[12] = '{0, c_cmp_lo,          32'h0,         4'b0000, 2'b00, 32'hDE22_BE44, 0};
        vecs[13] = '{0, c_cmp_hi,          32'h0,         4'b0000, 2'b00, 32'hFFFF_FFFF, 0};
        bad_addrs[0] = c_base + 32'h1000;
        bad_addrs[1] = c_base + 32'h4008;
        bad_addrs[2] = c_base + 32'hBFF4;
        bad_addrs[3] = c_base + 32'h8000;

        // reset state
        #12;
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 1);
        chk("rst_arready", arready, 1);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_resp", {bresp, rresp}, 0);
        chk("rst_irq", {mtip, msip}, 0);

        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        axi_read(c_t_lo, 0, v, r);
        chk_rng("mtime_after_10", v, 9, 11);
        chk("mtime_rresp", r, 0);
        chk("mtip_idle", mtip, 0);

        // directed table
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, i % 3, (i + 1) % 3, i % 2, r);
                chk($sformatf("vec%0d_bresp", i), r, vecs[i].resp);
            end else begin
                axi_read(vecs[i].addr, i % 2, v, r);
                chk($sformatf("vec%0d_rresp", i), r, vecs[i].resp);
                chk($sformatf("vec%0d_rdata", i), v, vecs[i].rdata);
            end
            chk($sformatf("vec%0d_msip", i), msip, vecs[i].msip);
        end

        // randomized traffic against a register-file model
        m_msip = 0;
        m_lo   = 32'hDE22_BE44;
        m_hi   = 32'hFFFF_FFFF;
        for (int n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 3);
            d    = $urandom;
            s    = 4'($urandom);
            case (pick)
                0:       a = c_msip;
                1:       a = c_cmp_lo;
                2:       a = c_cmp_hi;
                default: a = bad_addrs[$urandom_range(0, 3)];
            endcase
            a = a | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), r);
                if (pick == 0 && s[0]) m_msip = d[0];
                if (pick == 1) m_lo = merge(m_lo, d, s);
                if (pick == 2) m_hi = merge(m_hi, d, s);
                chk("rnd_bresp", r, (pick == 3) ? 2'b10 : 2'b00);
            end else begin
                axi_read(a, $urandom_range(0, 2), v, r);
                exp_d = (pick == 0) ? {31'b0, m_msip} : (pick == 1) ? m_lo : (pick == 2) ? m_hi : 32'h0;
                chk("rnd_rresp", r, (pick == 3) ? 2'b10 : 2'b00);
                chk("rnd_rdata", v, exp_d);
            end
            chk("rnd_msip", msip, m_msip);
        end

        // timer interrupt: mtimecmp = 0x20, mtime restarted from 0
        axi_write(c_cmp_hi, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r);
        axi_write(c_cmp_lo, 32'h20, 4'hF, 0, 0, 0, r);
        axi_write(c_t_hi, 32'h0, 4'hF, 0, 0, 0, r);
        axi_write(c_t_lo, 32'h0, 4'hF, 0, 0, 0, r);
        axi_write(c_cmp_hi, 32'h0, 4'hF, 0, 0, 0, r);
        axi_read(c_t_lo, 0, v, r);
        chk_rng("mtime_restart", v, 0, 32'h1F);
        chk("mtip_before", mtip, 0);
        n_wait = 0;
        while (!mtip && n_wait < 100) begin
            @(posedge clk); #1;
            n_wait++;
        end
        chk("mtip_rise", mtip, 1);
        axi_read(c_t_lo, 0, v, r);
        chk_rng("mtip_rise_time", v, 32'h20, 32'h24);
        axi_write(c_cmp_hi, 32'h1, 4'hF, 0, 0, 0, r);
        @(posedge clk); #1;
        chk("mtip_clear", mtip, 0);

        // W three cycles before AW, BREADY held low four cycles
        axi_write(c_cmp_lo, 32'hA5A5_0F0F, 4'hF, 3, 0, 4, r);
        chk("wfirst_bresp", r, 0);
        axi_read(c_cmp_lo, 0, v, r);
        chk("wfirst_data", v, 32'hA5A5_0F0F);

        // carry from lo into hi
        axi_write(c_t_hi, 32'h0, 4'hF, 0, 0, 0, r);
        axi_write(c_t_lo, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r);
        axi_read(c_t_lo, 0, v, r);
        chk_rng("wrap_lo", v, 0, 8);
        axi_read(c_t_hi, 0, v, r);
        chk("wrap_hi", v, 1);

        // shadowed hi across a carry, then live hi
        axi_write(c_t_hi, 32'h5, 4'hF, 0, 0, 0, r);
        axi_write(c_t_lo, 32'hFFFF_FFF0, 4'hF, 0, 0, 0, r);
        axi_read(c_t_lo, 0, v, r);
        chk_rng("shadow_lo", v, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        repeat (40) @(posedge clk);
        #1;
        axi_read(c_t_hi, 0, v2, r);
        chk("shadow_hi", v2, 5);
        axi_read(c_t_hi, 0, v2, r);
        chk("live_hi", v2, 6);

        // reset in the middle of a read
        axi_write(c_msip, 32'h1, 4'h1, 0, 0, 0, r);
        araddr  = c_cmp_lo;
        arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("midrd_rvalid", rvalid, 1);
        rst = 1'b1;
        #1;
        chk("midrd_rst_rvalid", rvalid, 0);
        chk("midrd_rst_arready", arready, 1);
        chk("midrd_rst_msip", msip, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        axi_read(c_cmp_hi, 0, v, r);
        chk("post_rst_cmp_hi", v, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
